// File: rtl/ldd_decode_pipe_pkg.sv
// ldd_pkg: shared definitions for the pipelined ldd control decoder.
//   - decode-table address map (primary entries first, then qualifier entries)
//   - stage record carried through both pipeline stages
//   - lowest-set-bit helper used to pick the qualifier entry
// The stage record and table are sized from the LDD_* constants below; the
// top-level parameters default to these, so widths are changed here.
package ldd_pkg;

  localparam int LDD_OP_W    = 3;
  localparam int LDD_QUAL_W  = 5;
  localparam int LDD_OUT_W   = 19;
  localparam int LDD_TAG_W   = 4;
  localparam int LDD_QUAL_OP = 0;
  localparam int LDD_CNT_W   = 16;

  localparam int LDD_IDX_W     = LDD_OP_W + 1;
  localparam int LDD_P_BASE    = 0;
  localparam int LDD_Q_BASE    = 2 ** (LDD_OP_W + 1);
  localparam int LDD_TBL_DEPTH = LDD_Q_BASE + LDD_QUAL_W + 1;
  localparam int LDD_ADDR_W    = $clog2(LDD_TBL_DEPTH);
  localparam int LDD_QK_W      = $clog2(LDD_QUAL_W + 1);

  typedef struct packed {
    logic                 valid;
    logic [LDD_OUT_W-1:0] word;
    logic [LDD_TAG_W-1:0] tag;
  } stage_t;

  // Qualifier entry index: 0 when no bit is set, else (lowest set bit + 1).
  function automatic logic [LDD_QK_W-1:0] lowest_set_k(input logic [LDD_QUAL_W-1:0] q);
    logic [LDD_QK_W-1:0] k;
    k = '0;
    // Scan from the top so the lowest set bit is the last one to win.
    for (int i = LDD_QUAL_W - 1; i >= 0; i--) begin
      if (q[i]) begin
        k = LDD_QK_W'(i + 1);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/ldd_decode_table.sv
// ldd_decode_table: run-time loadable decode table.
//   clk, rst_n            : clock, async active-low reset (clears every entry)
//   cfg_we/addr/data      : single write port; addresses past the table are ignored
//   rd_idx                : primary index {op, en}
//   rd_qual, rd_qual_en   : qualifier bits and whether to merge a qualifier entry
//   rd_word               : combinational lookup result
// The read port sees the registered table, so a write in the same cycle as a
// lookup of the same entry returns the old contents.
module ldd_decode_table
  import ldd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [LDD_ADDR_W-1:0] cfg_addr,
  input  logic [LDD_OUT_W-1:0]  cfg_data,
  input  logic [LDD_IDX_W-1:0]  rd_idx,
  input  logic [LDD_QUAL_W-1:0] rd_qual,
  input  logic                  rd_qual_en,
  output logic [LDD_OUT_W-1:0]  rd_word
);

  logic [LDD_OUT_W-1:0]  tbl_q [LDD_TBL_DEPTH];
  logic [LDD_OUT_W-1:0]  tbl_d [LDD_TBL_DEPTH];
  logic [LDD_ADDR_W-1:0] p_addr_s;
  logic [LDD_ADDR_W-1:0] q_addr_s;

  // Next table contents: apply an in-range write, otherwise hold.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && (cfg_addr < LDD_ADDR_W'(LDD_TBL_DEPTH))) begin
      tbl_d[cfg_addr] = cfg_data;
    end else begin
      tbl_d = tbl_q;
    end
  end

  // Table storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LDD_TBL_DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign p_addr_s = LDD_ADDR_W'(LDD_P_BASE) + LDD_ADDR_W'(rd_idx);
  assign q_addr_s = LDD_ADDR_W'(LDD_Q_BASE) + LDD_ADDR_W'(lowest_set_k(rd_qual));

  // Lookup: primary entry, OR-merged with the qualifier entry when enabled.
  always_comb begin
    rd_word = tbl_q[p_addr_s];
    if (rd_qual_en) begin
      rd_word = tbl_q[p_addr_s] | tbl_q[q_addr_s];
    end else begin
      rd_word = tbl_q[p_addr_s];
    end
  end

endmodule

// File: rtl/ldd_decode_pipe.sv
// ldd_decode_pipe: two-stage valid/ready decoder from {op, en, qual} to a
// multi-hot control word, with the mapping held in a loadable table.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : command handshake; in_op/in_en/in_qual/in_tag payload
//   cfg_we/cfg_addr/cfg_data: decode table write port
//   out_valid/out_ready     : result handshake; out_word/out_tag payload (registered)
//   busy                    : any stage holds a command
//   zero_cnt                : saturating count of all-zero results delivered
// Optional: define LDD_ZERO_CNT_EN to build the zero-result counter;
// otherwise zero_cnt is tied to zero.
module ldd_decode_pipe
  import ldd_pkg::*;
#(
  parameter int OP_W    = LDD_OP_W,
  parameter int QUAL_W  = LDD_QUAL_W,
  parameter int OUT_W   = LDD_OUT_W,
  parameter int TAG_W   = LDD_TAG_W,
  parameter int QUAL_OP = LDD_QUAL_OP,
  parameter int CNT_W   = LDD_CNT_W
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [OP_W-1:0]                              in_op,
  input  logic                                         in_en,
  input  logic [QUAL_W-1:0]                            in_qual,
  input  logic [TAG_W-1:0]                             in_tag,
  input  logic                                         cfg_we,
  input  logic [$clog2(2**(OP_W+1)+QUAL_W+1)-1:0]      cfg_addr,
  input  logic [OUT_W-1:0]                             cfg_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUT_W-1:0]                             out_word,
  output logic [TAG_W-1:0]                             out_tag,
  output logic                                         busy,
  output logic [CNT_W-1:0]                             zero_cnt
);

  stage_t             s1_q, s1_d;
  stage_t             s2_q, s2_d;
  logic               adv_s;
  logic               accept_s;
  logic [OUT_W-1:0]   lookup_s;

  ldd_decode_table u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .rd_idx     ({in_op, in_en}),
    .rd_qual    (in_qual),
    .rd_qual_en (in_op == OP_W'(QUAL_OP)),
    .rd_word    (lookup_s)
  );

  // Stage 2 can take new data when empty or when its content is being consumed.
  assign adv_s    = !s2_q.valid || out_ready;
  assign in_ready = !s1_q.valid || adv_s;
  assign accept_s = in_valid && in_ready;

  // Pipeline next-state: s1 moves into s2 on advance; s1 loads on accept.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (adv_s) begin
      s2_d = s1_q;
    end else begin
      s2_d = s2_q;
    end
    if (accept_s) begin
      s1_d.valid = 1'b1;
      s1_d.word  = lookup_s;
      s1_d.tag   = in_tag;
    end else if (adv_s) begin
      s1_d.valid = 1'b0;
    end else begin
      s1_d = s1_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid = s2_q.valid;
  assign out_word  = s2_q.word;
  assign out_tag   = s2_q.tag;
  assign busy      = s1_q.valid || s2_q.valid;

`ifdef LDD_ZERO_CNT_EN
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  // Count delivered all-zero words, holding at the maximum value.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (s2_q.valid && out_ready && (s2_q.word == '0) && (zero_cnt_q != '1)) begin
      zero_cnt_d = zero_cnt_q + CNT_W'(1);
    end else begin
      zero_cnt_d = zero_cnt_q;
    end
  end

  // Zero-result counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
`else
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_ldd_decode_pipe.sv
module tb_ldd_decode_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_en;
  logic [4:0]  in_qual;
  logic [3:0]  in_tag;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [18:0] cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_word;
  logic [3:0]  out_tag;
  logic        busy;
  logic [15:0] zero_cnt;

  typedef struct {
    logic [18:0] word;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [18:0] model_tbl [22];
  int          checks;
  int          errors;
  int          n_out;

  ldd_decode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_en     (in_en),
    .in_qual   (in_qual),
    .in_tag    (in_tag),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_tag   (out_tag),
    .busy      (busy),
    .zero_cnt  (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference decode: primary entry, plus qualifier entry for op 0.
  function automatic logic [18:0] model_decode(input logic [2:0] op, input logic en,
                                               input logic [4:0] qual);
    logic [4:0]  pa;
    logic [4:0]  qa;
    logic [18:0] w;
    pa = {1'b0, op, en};
    w  = model_tbl[pa];
    if (op == 3'd0) begin
      qa = 5'd16;
      for (int i = 4; i >= 0; i--) begin
        if (qual[i]) qa = 5'd16 + 5'(i + 1);
      end
      w = w | model_tbl[qa];
    end
    return w;
  endfunction

  // Scoreboard: check deliveries, record accepts, then track table writes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word=%h tag=%h, expected no output", out_word, out_tag);
        end else begin
          e = sb_q.pop_front();
          n_out++;
          if (out_word !== e.word || out_tag !== e.tag) begin
            errors++;
            $display("FAIL sb_data: got word=%h tag=%h, expected word=%h tag=%h",
                     out_word, out_tag, e.word, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.word = model_decode(in_op, in_en, in_qual);
        e.tag  = in_tag;
        sb_q.push_back(e);
      end
      if (cfg_we && cfg_addr < 5'd22) model_tbl[cfg_addr] = cfg_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 22; i++) model_tbl[i] = 19'd0;
    sb_q.delete();
  endtask

  // Present one command and hold it until accepted; returns stall cycles.
  task automatic send_cmd(input logic [2:0] op, input logic en, input logic [4:0] qual,
                          input logic [3:0] tag, output int waited);
    in_valid = 1'b1;
    in_op    = op;
    in_en    = en;
    in_qual  = qual;
    in_tag   = tag;
    waited   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [18:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      tick();
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, expected pending=0 busy=0", sb_q.size(), busy);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        out_word !== 19'd0 || out_tag !== 4'd0 || zero_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: ov=%b busy=%b ir=%b word=%h tag=%h zc=%0d, expected 0 0 1 0 0 0",
               name, out_valid, busy, in_ready, out_word, out_tag, zero_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_en = 1'b0; in_qual = 5'd0;
    in_tag = 4'd0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 19'd0; out_ready = 1'b1;
    clear_model();
    tick();
    tick();
    check_idle("reset_state");
    rst_n = 1'b1;
    tick();
    check_idle("after_reset_release");
  endtask

  task automatic test_zero_default();
    int w;
    send_cmd(3'd0, 1'b1, 5'd0, 4'd3, w);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_lat1: busy=%b ov=%b, expected busy=1 ov=0", busy, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_word !== 19'd0 || out_tag !== 4'd3) begin
      errors++;
      $display("FAIL zero_lat2: ov=%b word=%h tag=%h, expected 1 00000 3", out_valid, out_word, out_tag);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: busy=%b ov=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_qual();
    int w;
    cfg_write(5'd1, 19'h00001);
    cfg_write(5'd19, 19'h00100);
    send_cmd(3'd0, 1'b1, 5'b00100, 4'd7, w);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL qual_lat1: ov=%b, expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_word !== 19'h00101 || out_tag !== 4'd7) begin
      errors++;
      $display("FAIL qual_word: ov=%b word=%h tag=%h, expected 1 00101 7", out_valid, out_word, out_tag);
    end
    drain();
  endtask

  task automatic test_nonqual();
    int w;
    cfg_write(5'd5, 19'h40000);
    cfg_write(5'd17, 19'h00010);
    cfg_write(5'd22, 19'h7FFFF);
    cfg_write(5'd31, 19'h7FFFF);
    send_cmd(3'd2, 1'b1, 5'b11111, 4'd1, w);
    tick();
    checks++;
    if (out_word !== 19'h40000 || out_tag !== 4'd1) begin
      errors++;
      $display("FAIL nonqual_word: word=%h tag=%h, expected 40000 1", out_word, out_tag);
    end
    send_cmd(3'd3, 1'b0, 5'd0, 4'd2, w);
    tick();
    checks++;
    if (out_word !== 19'h00000 || out_tag !== 4'd2) begin
      errors++;
      $display("FAIL oob_write: word=%h tag=%h, expected 00000 2", out_word, out_tag);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int          w;
    int          base_out;
    logic [18:0] first_word;
    logic [2:0]  ops[6];
    logic        ens[6];
    for (int i = 8; i < 16; i++) cfg_write(5'(i), 19'(i * 32'h2345 + 32'h11));
    for (int i = 0; i < 6; i++) begin
      ops[i] = 3'(4 + i / 2);
      ens[i] = 1'(i % 2);
    end
    first_word = model_tbl[5'd8];
    base_out   = n_out;
    out_ready  = 1'b0;
    send_cmd(ops[0], ens[0], 5'd0, 4'd10, w);
    send_cmd(ops[1], ens[1], 5'd0, 4'd11, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL b2b_second_accept: stalled %0d cycles, expected 0", w);
    end
    in_valid = 1'b1; in_op = ops[2]; in_en = ens[2]; in_qual = 5'd0; in_tag = 4'd12;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== first_word || out_tag !== 4'd10) begin
        errors++;
        $display("FAIL b2b_full: ir=%b ov=%b word=%h tag=%h, expected 0 1 %h a",
                 in_ready, out_valid, out_word, out_tag, first_word);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) send_cmd(ops[i], ens[i], 5'd0, 4'(10 + i), w);
    drain();
    checks++;
    if (n_out - base_out != 6) begin
      errors++;
      $display("FAIL b2b_count: delivered %0d, expected 6", n_out - base_out);
    end
  endtask

  task automatic test_same_cycle();
    int w;
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 19'h2AAAA;
    send_cmd(3'd0, 1'b1, 5'd0, 4'd4, w);
    cfg_we = 1'b0;
    send_cmd(3'd0, 1'b1, 5'd0, 4'd5, w);
    checks++;
    if (out_word !== 19'h00001 || out_tag !== 4'd4) begin
      errors++;
      $display("FAIL same_cycle_old: word=%h tag=%h, expected 00001 4", out_word, out_tag);
    end
    tick();
    checks++;
    if (out_word !== 19'h2AAAA || out_tag !== 4'd5) begin
      errors++;
      $display("FAIL same_cycle_new: word=%h tag=%h, expected 2aaaa 5", out_word, out_tag);
    end
    drain();
  endtask

  task automatic test_zero_cnt_and_reset();
    int          w;
    logic [15:0] exp_cnt;
    rst_n = 1'b0;
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send_cmd(3'd1, 1'b1, 5'd0, 4'(i), w);
    cfg_write(5'd2, 19'h00007);
    send_cmd(3'd1, 1'b0, 5'd0, 4'd9, w);
    drain();
`ifdef LDD_ZERO_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (zero_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL zero_cnt: got %0d, expected %0d", zero_cnt, exp_cnt);
    end
    out_ready = 1'b0;
    send_cmd(3'd1, 1'b0, 5'd0, 4'd1, w);
    send_cmd(3'd1, 1'b1, 5'd0, 4'd2, w);
    rst_n = 1'b0;
    #1;
    clear_model();
    check_idle("midstream_reset");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_cmd(3'd1, 1'b0, 5'd0, 4'd6, w);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_word !== 19'd0 || out_tag !== 4'd6) begin
      errors++;
      $display("FAIL table_cleared: ov=%b word=%h tag=%h, expected 1 00000 6", out_valid, out_word, out_tag);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_out  = 0;
    test_reset();
    test_zero_default();
    test_qual();
    test_nonqual();
    test_back_to_back();
    test_same_cycle();
    test_zero_cnt_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
